// File: rtl/load_store_unit.sv
// Purpose: MEM-stage access unit turning MIPS byte/half/word loads and stores into word-only memory accesses.
// Latency: loads and word stores take 1 cycle; sub-word stores take 2 cycles (read-modify-write, memory written on the second edge).
// Backpressure: stall is raised during the read half of a sub-word store; the pipeline holds the same instruction for the write cycle.
module load_store_unit #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Decoded request attributes
    logic        is_load;
    logic        is_half;
    logic        is_word;
    logic        aligned;
    logic [1:0]  byte_lane;
    logic        half_hi;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;
    logic [31:0] merged_word;

    // Held read-modify-write store
    logic [31:0] rmw_data_q;
    logic [31:0] rmw_addr_q;

    // FSM-qualified events
    logic        load_fire;
    logic        misalign_fire;
    logic        capture_rmw;

    // Decode the op, check alignment and pick the byte/halfword lane for the current endianness
    always_comb begin
        is_load   = (req_op == OP_LB) || (req_op == OP_LH) || (req_op == OP_LW) ||
                    (req_op == OP_LBU) || (req_op == OP_LHU);
        is_half   = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
        is_word   = (req_op == OP_LW) || (req_op == OP_SW);
        aligned   = 1'b1;
        if (is_word) begin
            aligned = (req_addr[1:0] == 2'b00);
        end else if (is_half) begin
            aligned = ~req_addr[0];
        end
        // Big-endian mirrors the lane order: address offset 0 is the most significant lane.
        byte_lane = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
        half_hi   = BIG_ENDIAN ? ~req_addr[1]   : req_addr[1];
    end

    // Extract the addressed lane from the read word and extend it to 32 bits
    always_comb begin
        sel_byte = mem_read_data[{byte_lane, 3'b000} +: 8];
        sel_half = half_hi ? mem_read_data[31:16] : mem_read_data[15:0];
        load_ext = mem_read_data;
        case (req_op)
            OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_ext = {24'h000000, sel_byte};
            OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_ext = {16'h0000, sel_half};
            default: load_ext = mem_read_data;
        endcase
    end

    // Merge sub-word store data into the lane of the current memory word
    always_comb begin
        merged_word = mem_read_data;
        if (req_op == OP_SB) begin
            merged_word[{byte_lane, 3'b000} +: 8] = req_wdata[7:0];
        end else if (req_op == OP_SH) begin
            if (half_hi) begin
                merged_word[31:16] = req_wdata[15:0];
            end else begin
                merged_word[15:0] = req_wdata[15:0];
            end
        end
    end

    // Next-state and memory-port control; stall and write are forced low while reset is held
    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        mem_write      = 1'b0;
        mem_address    = {req_addr[31:2], 2'b00};
        mem_write_data = req_wdata;
        load_fire      = 1'b0;
        misalign_fire  = 1'b0;
        capture_rmw    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!aligned) begin
                        misalign_fire = 1'b1;
                    end else if (is_load) begin
                        load_fire = 1'b1;
                    end else if (req_op == OP_SW) begin
                        mem_write = 1'b1;
                    end else begin
                        // SB/SH: read this cycle, write the merged word next cycle.
                        stall       = 1'b1;
                        capture_rmw = 1'b1;
                        state_d     = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                // Request inputs are ignored here; the pipeline is still presenting the same store.
                mem_write      = 1'b1;
                mem_address    = rmw_addr_q;
                mem_write_data = rmw_data_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!reset) begin
            stall     = 1'b0;
            mem_write = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load result and one-cycle status pulses; load_data holds unless a valid aligned load completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_data  <= 32'h0000_0000;
            load_valid <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            load_valid <= load_fire;
            misaligned <= misalign_fire;
            if (load_fire) begin
                load_data <= load_ext;
            end
        end
    end

    // Capture the merged word and its word address for the write cycle of a sub-word store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rmw_data_q <= 32'h0000_0000;
            rmw_addr_q <= 32'h0000_0000;
        end else if (capture_rmw) begin
            rmw_data_q <= merged_word;
            rmw_addr_q <= {req_addr[31:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: directed self-checking bench for load_store_unit in both byte orders, each with its own word memory model.
// Latency: memory model reads combinationally and writes on the rising edge.
// Backpressure: the bench holds each sub-word store for its two cycles, as a stalled pipeline would.
module tb_load_store_unit;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic        be_stall;
    logic [31:0] be_load_data;
    logic        be_load_valid;
    logic        be_misaligned;
    logic        be_mem_write;
    logic [31:0] be_mem_address;
    logic [31:0] be_mem_write_data;
    logic [31:0] be_mem_read_data;

    logic [31:0] mem    [16];
    logic [31:0] be_mem [16];

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0]  ld_op  [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    logic [31:0] ld_addr[5] = '{32'hB, 32'hB, 32'hA, 32'hA, 32'h8};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8022, 32'h0000_8022, 32'h8022_3344};

    load_store_unit #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .misaligned     (misaligned),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    load_store_unit #(.BIG_ENDIAN(1'b1)) dut_be (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (be_stall),
        .load_data      (be_load_data),
        .load_valid     (be_load_valid),
        .misaligned     (be_misaligned),
        .mem_write      (be_mem_write),
        .mem_address    (be_mem_address),
        .mem_write_data (be_mem_write_data),
        .mem_read_data  (be_mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data    = mem[mem_address[5:2]];
    assign be_mem_read_data = be_mem[be_mem_address[5:2]];

    // Data_memory models: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[5:2]] <= mem_write_data;
        if (be_mem_write) be_mem[be_mem_address[5:2]] <= be_mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h4;
        req_wdata = 32'h1234_5678;
        #2;
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Preload words with aligned word stores
        apply(1'b1, OP_SW, 32'h4, 32'h1122_3344);
        check("sw_mem_write", {31'd0, mem_write}, 32'd1);
        check("sw_stall", {31'd0, stall}, 32'd0);
        check("sw_wdata", mem_write_data, 32'h1122_3344);
        step();
        apply(1'b1, OP_SW, 32'h8, 32'h8022_3344);
        step();
        check("sw_mem4", mem[1], 32'h1122_3344);

        // SB to 0x5: stall in cycle 1, write in cycle 2
        apply(1'b1, OP_SB, 32'h5, 32'h0000_00AB);
        check("sb_c1_stall", {31'd0, stall}, 32'd1);
        check("sb_c1_mem_write", {31'd0, mem_write}, 32'd0);
        step();
        check("sb_c2_stall", {31'd0, stall}, 32'd0);
        check("sb_c2_mem_write", {31'd0, mem_write}, 32'd1);
        check("sb_c2_addr", mem_address, 32'h4);
        check("sb_c2_wdata", mem_write_data, 32'h1122_AB44);
        step();
        check("sb_mem4", mem[1], 32'h1122_AB44);

        // Loads from word 0x8 = 0x80223344
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, ld_op[i], ld_addr[i], 32'd0);
            check("ld_stall", {31'd0, stall}, 32'd0);
            check("ld_mem_write", {31'd0, mem_write}, 32'd0);
            step();
            check("ld_data", load_data, ld_exp[i]);
            check("ld_valid", {31'd0, load_valid}, 32'd1);
        end
        apply(1'b0, OP_LW, 32'h0, 32'd0);
        step();
        check("ld_valid_drop", {31'd0, load_valid}, 32'd0);

        // Misaligned SH 0x3 and LW 0x6
        apply(1'b1, OP_SH, 32'h3, 32'h0000_FFFF);
        check("mis_sh_mem_write", {31'd0, mem_write}, 32'd0);
        check("mis_sh_stall", {31'd0, stall}, 32'd0);
        step();
        check("mis_sh_flag", {31'd0, misaligned}, 32'd1);
        check("mis_sh_valid", {31'd0, load_valid}, 32'd0);
        check("mis_sh_hold", load_data, 32'h8022_3344);
        apply(1'b1, OP_LW, 32'h6, 32'd0);
        check("mis_lw_mem_write", {31'd0, mem_write}, 32'd0);
        step();
        check("mis_lw_flag", {31'd0, misaligned}, 32'd1);
        check("mis_lw_valid", {31'd0, load_valid}, 32'd0);
        check("mis_lw_hold", load_data, 32'h8022_3344);
        apply(1'b0, OP_LW, 32'h0, 32'd0);
        step();
        check("mis_drop", {31'd0, misaligned}, 32'd0);
        check("mis_mem4", mem[1], 32'h1122_AB44);

        // SH 0x6 then LW 0x4 in the very next cycle
        apply(1'b1, OP_SW, 32'h4, 32'h0);
        step();
        apply(1'b1, OP_SH, 32'h6, 32'h0000_BEEF);
        check("sh_c1_stall", {31'd0, stall}, 32'd1);
        step();
        check("sh_c2_wdata", mem_write_data, 32'hBEEF_0000);
        step();
        apply(1'b1, OP_LW, 32'h4, 32'd0);
        step();
        check("sh_then_lw", load_data, 32'hBEEF_0000);
        check("sh_then_lw_valid", {31'd0, load_valid}, 32'd1);

        // Back-to-back sub-word stores to word 0x8
        apply(1'b1, OP_SB, 32'h9, 32'h0000_0011);
        step();
        step();
        apply(1'b1, OP_SB, 32'hA, 32'h0000_0077);
        check("b2b_c1_stall", {31'd0, stall}, 32'd1);
        step();
        check("b2b_c2_wdata", mem_write_data, 32'h8077_1144);
        step();
        check("b2b_mem8", mem[2], 32'h8077_1144);

        // Reset during RMW_WR of SB to 0x0
        apply(1'b1, OP_SW, 32'h0, 32'hCAFE_F00D);
        step();
        apply(1'b1, OP_SB, 32'h0, 32'h0000_0055);
        step();
        check("rmw_pre_write", {31'd0, mem_write}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rmwrst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rmwrst_stall", {31'd0, stall}, 32'd0);
        check("rmwrst_load_data", load_data, 32'd0);
        check("rmwrst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rmwrst_misaligned", {31'd0, misaligned}, 32'd0);
        step();
        check("rmwrst_mem0", mem[0], 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_mem_write", {31'd0, mem_write}, 32'd0);

        // Big-endian instance
        apply(1'b1, OP_SW, 32'h0, 32'h1122_3344);
        step();
        apply(1'b1, OP_LBU, 32'h0, 32'd0);
        step();
        check("be_lbu", be_load_data, 32'h0000_0011);
        check("be_lbu_valid", {31'd0, be_load_valid}, 32'd1);
        apply(1'b1, OP_LH, 32'h0, 32'd0);
        step();
        check("be_lh", be_load_data, 32'h0000_1122);
        apply(1'b1, OP_SB, 32'h3, 32'h0000_00CD);
        check("be_sb_stall", {31'd0, be_stall}, 32'd1);
        step();
        check("be_sb_wdata", be_mem_write_data, 32'h1122_33CD);
        step();
        check("be_sb_mem0", be_mem[0], 32'h1122_33CD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
